// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Two-requester arbiter for the unified memory of a multi-cycle CPU. Instruction
// fetch and load/store data share one fixed-latency memory port. An access is
// granted in IDLE, drives the memory for MEM_LAT cycles in ACCESS, and is
// acknowledged with a done pulse that leads into a single RESP cycle. Every
// output is a flop; the *_d values are computed in one combinational process.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 2,
  parameter int FAIR    = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_done,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_done,
  output logic [DW-1:0] rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          iord,
  output logic          busy
);

  localparam int            CW       = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(MEM_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  // 1 when the data requester was the most recent owner
  logic          last_data_q, last_data_d;
  logic          if_gnt_q, if_gnt_d;
  logic          if_done_q, if_done_d;
  logic          d_gnt_q, d_gnt_d;
  logic          d_done_q, d_done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          mem_en_q, mem_en_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  // iord doubles as the owner flag for the whole ACCESS/RESP span
  logic          iord_q, iord_d;
  logic          busy_q, busy_d;
  logic          pick_data;

  // Owner selection for an IDLE sample: a lone request wins; a conflict goes to
  // data, or in fair mode to whichever requester was not served last.
  always_comb begin
    pick_data = 1'b0;
    if (d_req && !if_req) begin
      pick_data = 1'b1;
    end else if (d_req && if_req) begin
      pick_data = (FAIR == 0) ? 1'b1 : !last_data_q;
    end
  end

  // Next-state and registered-output logic for IDLE -> ACCESS -> RESP -> IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_data_d = last_data_q;
    if_gnt_d    = 1'b0;
    if_done_d   = 1'b0;
    d_gnt_d     = 1'b0;
    d_done_d    = 1'b0;
    rdata_d     = rdata_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    iord_d      = iord_q;
    unique case (state_q)
      S_IDLE: begin
        if (if_req || d_req) begin
          state_d     = S_ACCESS;
          cnt_d       = CNT_LOAD;
          last_data_d = pick_data;
          iord_d      = pick_data;
          d_gnt_d     = pick_data;
          if_gnt_d    = !pick_data;
          mem_en_d    = 1'b1;
          mem_we_d    = pick_data & d_we;
          mem_addr_d  = pick_data ? d_addr : if_addr;
          mem_wdata_d = pick_data ? d_wdata : '0;
        end
      end
      S_ACCESS: begin
        if (cnt_q == '0) begin
          // Last memory cycle: mem_rdata is valid now for a read.
          state_d  = S_RESP;
          mem_en_d = 1'b0;
          mem_we_d = 1'b0;
          if (!mem_we_q) begin
            rdata_d = mem_rdata;
          end
          d_done_d  = iord_q;
          if_done_d = !iord_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        iord_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      last_data_q <= 1'b1;
      if_gnt_q    <= 1'b0;
      if_done_q   <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_done_q    <= 1'b0;
      rdata_q     <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      iord_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_data_q <= last_data_d;
      if_gnt_q    <= if_gnt_d;
      if_done_q   <= if_done_d;
      d_gnt_q     <= d_gnt_d;
      d_done_q    <= d_done_d;
      rdata_q     <= rdata_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      iord_q      <= iord_d;
      busy_q      <= busy_d;
    end
  end

  assign if_gnt    = if_gnt_q;
  assign if_done   = if_done_q;
  assign d_gnt     = d_gnt_q;
  assign d_done    = d_done_q;
  assign rdata     = rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign iord      = iord_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter. Three instances share one clock:
//   0: MEM_LAT=2 FAIR=0, 1: MEM_LAT=2 FAIR=1, 2: MEM_LAT=1 FAIR=0.
// Each instance has its own small memory model that returns read data only on
// the last mem_en cycle (garbage before), so early or late capture shows up.
module tb_mem_port_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        if_req    [N];
  logic [31:0] if_addr   [N];
  logic        if_gnt    [N];
  logic        if_done   [N];
  logic        d_req     [N];
  logic        d_we      [N];
  logic [31:0] d_addr    [N];
  logic [31:0] d_wdata   [N];
  logic        d_gnt     [N];
  logic        d_done    [N];
  logic [31:0] rdata     [N];
  logic        mem_en    [N];
  logic        mem_we    [N];
  logic [31:0] mem_addr  [N];
  logic [31:0] mem_wdata [N];
  logic [31:0] mem_rdata [N];
  logic        iord      [N];
  logic        busy      [N];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int          g;
    bit          is_data;
    logic [31:0] rdata;
  } exp_t;

  typedef struct {
    bit          is_data;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  exp_t sb [$];
  int   gnt_cyc  [$];
  bit   gnt_dat  [$];
  int   done_cyc [$];

  // Contents of a never-written memory word.
  function automatic logic [31:0] defpat(input logic [31:0] a);
    return a ^ 32'h2010_0045;
  endfunction

  function automatic int lat_of(input int g);
    return (g == 2) ? 1 : 2;
  endfunction

  for (genvar gi = 0; gi < N; gi++) begin : g_dut
    localparam int LAT = (gi == 2) ? 1 : 2;
    logic [31:0] store [256];
    bit          valid [256];
    int          en_run = 0;
    logic [7:0]  idx;

    assign idx = mem_addr[gi][9:2];

    mem_port_arbiter #(
      .AW(32), .DW(32), .MEM_LAT(LAT), .FAIR((gi == 1) ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req[gi]), .if_addr(if_addr[gi]),
      .if_gnt(if_gnt[gi]), .if_done(if_done[gi]),
      .d_req(d_req[gi]), .d_we(d_we[gi]), .d_addr(d_addr[gi]), .d_wdata(d_wdata[gi]),
      .d_gnt(d_gnt[gi]), .d_done(d_done[gi]),
      .rdata(rdata[gi]),
      .mem_en(mem_en[gi]), .mem_we(mem_we[gi]), .mem_addr(mem_addr[gi]),
      .mem_wdata(mem_wdata[gi]), .mem_rdata(mem_rdata[gi]),
      .iord(iord[gi]), .busy(busy[gi])
    );

    always @(posedge clk) begin
      if (mem_en[gi]) en_run <= en_run + 1;
      else            en_run <= 0;
      if (mem_en[gi] && mem_we[gi]) begin
        store[idx] <= mem_wdata[gi];
        valid[idx] <= 1'b1;
      end
    end

    assign mem_rdata[gi] = !mem_en[gi]          ? 32'h0 :
                           (en_run != LAT - 1)  ? (32'hBAD0_0000 ^ mem_addr[gi]) :
                           valid[idx]           ? store[idx] : defpat(mem_addr[gi]);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs(input int g);
    return {24'd0, if_gnt[g], if_done[g], d_gnt[g], d_done[g],
            mem_en[g], mem_we[g], iord[g], busy[g]};
  endfunction

  // Scoreboard side: every done pops the oldest expected completion.
  always @(negedge clk) begin
    for (int g = 0; g < N; g++) begin
      if (if_gnt[g] || d_gnt[g]) check("gnt_exclusive", {31'd0, if_gnt[g] & d_gnt[g]}, 32'd0);
      if (if_done[g] || d_done[g]) begin
        check("done_exclusive", {31'd0, if_done[g] & d_done[g]}, 32'd0);
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL done_unexpected: inst %0d raised done, expected none", g);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("sb_inst", g, e.g);
          check("sb_owner", {31'd0, d_done[g]}, {31'd0, e.is_data});
          check("sb_rdata", rdata[g], e.rdata);
          $display("done inst=%0d owner=%s rdata=0x%08h", g, d_done[g] ? "data" : "fetch", rdata[g]);
        end
      end
    end
  end

  // One access through the table path, with per-cycle protocol checks.
  task automatic do_access(input int g, input vec_t v);
    bit   got;
    bit   fin;
    int   en_cnt;
    exp_t e;
    got = 1'b0;
    fin = 1'b0;
    en_cnt = 0;
    @(negedge clk);
    if (v.is_data) begin
      d_req[g] = 1'b1; d_we[g] = v.we; d_addr[g] = v.addr; d_wdata[g] = v.wdata;
    end else begin
      if_req[g] = 1'b1; if_addr[g] = v.addr;
    end
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = if_gnt[g] | d_gnt[g];
    end
    check("acc_gnt_seen", {31'd0, got}, 32'd1);
    if_req[g] = 1'b0;
    d_req[g]  = 1'b0;
    if (!got) return;
    check("acc_gnt_owner", {30'd0, d_gnt[g], if_gnt[g]}, v.is_data ? 32'd2 : 32'd1);
    check("acc_mem_addr", mem_addr[g], v.addr);
    check("acc_mem_we", {31'd0, mem_we[g]}, {31'd0, v.is_data & v.we});
    check("acc_iord", {31'd0, iord[g]}, {31'd0, v.is_data});
    if (v.is_data && v.we) check("acc_mem_wdata", mem_wdata[g], v.wdata);
    e.g = g; e.is_data = v.is_data; e.rdata = v.exp_rdata;
    sb.push_back(e);
    // Changes after acceptance must not disturb the access in flight.
    d_we[g] = ~v.we; d_addr[g] = ~v.addr; d_wdata[g] = ~v.wdata; if_addr[g] = ~v.addr;
    for (int c = 0; c < 20 && !fin; c++) begin
      if (mem_en[g]) en_cnt++;
      @(negedge clk);
      fin = if_done[g] | d_done[g];
    end
    check("acc_done_seen", {31'd0, fin}, 32'd1);
    check("acc_en_cycles", en_cnt, lat_of(g));
    check("acc_en_drop", {31'd0, mem_en[g]}, 32'd0);
    check("acc_busy_iord_resp", {30'd0, busy[g], iord[g]}, {30'd0, 1'b1, v.is_data});
    @(negedge clk);
    check("acc_idle", {30'd0, busy[g], iord[g]}, 32'd0);
    $display("access inst=%0d %s addr=0x%08h en_cycles=%0d", g,
             v.is_data ? (v.we ? "store" : "load") : "fetch", v.addr, en_cnt);
  endtask

  // Multi-cycle request pattern: loads from 0x300 (data) and fetches from 0x200.
  // Requesters drop req in the gnt cycle unless hold is set, then re-raise.
  task automatic burst(input int g, input int n_if, input int n_d, input bit hold, input int ncyc);
    int   rem_if;
    int   rem_d;
    bit   g_if;
    bit   g_d;
    exp_t e;
    rem_if = n_if;
    rem_d  = n_d;
    gnt_cyc.delete(); gnt_dat.delete(); done_cyc.delete();
    @(negedge clk);
    if_addr[g] = 32'h200; d_addr[g] = 32'h300; d_we[g] = 1'b0; d_wdata[g] = '0;
    if_req[g] = (rem_if > 0);
    d_req[g]  = (rem_d > 0);
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      g_if = if_gnt[g];
      g_d  = d_gnt[g];
      if (g_if) begin
        gnt_cyc.push_back(c); gnt_dat.push_back(1'b0); rem_if--;
        e.g = g; e.is_data = 1'b0; e.rdata = defpat(32'h200); sb.push_back(e);
        $display("grant inst=%0d cycle=%0d owner=fetch", g, c);
      end
      if (g_d) begin
        gnt_cyc.push_back(c); gnt_dat.push_back(1'b1); rem_d--;
        e.g = g; e.is_data = 1'b1; e.rdata = defpat(32'h300); sb.push_back(e);
        $display("grant inst=%0d cycle=%0d owner=data", g, c);
      end
      if (if_done[g] || d_done[g]) done_cyc.push_back(c);
      if_req[g] = (rem_if > 0) && (hold || !g_if);
      d_req[g]  = (rem_d > 0) && (hold || !g_d);
    end
    if_req[g] = 1'b0;
    d_req[g]  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl [7];
    bit   got;
    int   ndone;
    logic [3:0] ord;

    tbl[0] = '{1'b0, 1'b0, 32'h40,  32'h0,         32'h2010_0005};
    tbl[1] = '{1'b1, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h2010_0005};
    tbl[2] = '{1'b1, 1'b0, 32'h100, 32'h0,         32'hDEAD_BEEF};
    tbl[3] = '{1'b0, 1'b0, 32'h44,  32'h0,         32'h2010_0001};
    tbl[4] = '{1'b1, 1'b1, 32'h44,  32'h1234_5678, 32'h2010_0001};
    tbl[5] = '{1'b0, 1'b0, 32'h44,  32'h0,         32'h1234_5678};
    tbl[6] = '{1'b1, 1'b0, 32'h80,  32'h0,         32'h2010_00C5};

    rst = 1'b1;
    for (int g = 0; g < N; g++) begin
      if_req[g] = 1'b0; if_addr[g] = '0;
      d_req[g] = 1'b0; d_we[g] = 1'b0; d_addr[g] = '0; d_wdata[g] = '0;
    end
    repeat (3) @(negedge clk);
    for (int g = 0; g < N; g++) begin
      check("rst_outputs", outs(g), 32'd0);
      check("rst_rdata", rdata[g], 32'd0);
      check("rst_mem_addr", mem_addr[g], 32'd0);
      $display("reset inst=%0d outs=0x%02h rdata=0x%08h", g, outs(g), rdata[g]);
    end
    rst = 1'b0;
    @(negedge clk);

    // Table-driven single accesses on the MEM_LAT=2 instance.
    for (int i = 0; i < 7; i++) do_access(0, tbl[i]);

    // Conflict, data priority: data first, fetch at the next IDLE sample.
    burst(0, 1, 1, 1'b0, 12);
    check("cf_gnt_count", gnt_cyc.size(), 32'd2);
    check("cf_done_count", done_cyc.size(), 32'd2);
    if (gnt_cyc.size() == 2 && done_cyc.size() == 2) begin
      check("cf_first_owner", {31'd0, gnt_dat[0]}, 32'd1);
      check("cf_second_owner", {31'd0, gnt_dat[1]}, 32'd0);
      check("cf_first_gnt_cycle", gnt_cyc[0], 32'd0);
      check("cf_data_done_lat", done_cyc[0] - gnt_cyc[0], 32'd2);
      check("cf_fetch_gnt_gap", gnt_cyc[1] - gnt_cyc[0], 32'd4);
      check("cf_fetch_done_lat", done_cyc[1] - gnt_cyc[1], 32'd2);
    end

    // Fair mode, both re-requesting: fetch, data, fetch, data.
    burst(1, 2, 2, 1'b0, 20);
    check("fair_gnt_count", gnt_cyc.size(), 32'd4);
    if (gnt_cyc.size() == 4) begin
      ord = {gnt_dat[0], gnt_dat[1], gnt_dat[2], gnt_dat[3]};
      check("fair_order", {28'd0, ord}, 32'h5);
      check("fair_gap", gnt_cyc[1] - gnt_cyc[0], 32'd4);
    end

    // MEM_LAT=1 with fetch held high: grant every 3 cycles, done one later.
    burst(2, 3, 0, 1'b1, 12);
    check("lat1_gnt_count", gnt_cyc.size(), 32'd3);
    check("lat1_done_count", done_cyc.size(), 32'd3);
    if (gnt_cyc.size() == 3 && done_cyc.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("lat1_done_lat", done_cyc[i] - gnt_cyc[i], 32'd1);
        if (i > 0) check("lat1_gnt_gap", gnt_cyc[i] - gnt_cyc[i-1], 32'd3);
      end
    end

    // Reset during the first ACCESS cycle abandons the fetch silently.
    got = 1'b0;
    @(negedge clk);
    if_req[0] = 1'b1; if_addr[0] = 32'h40;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      got = if_gnt[0];
    end
    check("rstmid_gnt_seen", {31'd0, got}, 32'd1);
    if_req[0] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_outputs", outs(0), 32'd0);
    check("rstmid_rdata", rdata[0], 32'd0);
    ndone = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if_done[0] || d_done[0]) ndone++;
    end
    check("rstmid_no_done", ndone, 32'd0);
    $display("reset-mid inst=0 outs=0x%02h dones_after=%0d", outs(0), ndone);

    check("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
